// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// with operands, partial sums and the group carry travelling together down the pipe.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / BLOCK;
    // The last group writes straight into z/cout/ovf, so only STAGES-1 stage registers exist.
    localparam int RS = (STAGES > 1) ? STAGES - 1 : 1;

    // Handshake: a beat moves on an edge where valid && ready are both high. The whole
    // pipe advances together whenever the output slot is empty or being drained.
    logic adv;
    logic last_v;
    logic ovf_n;

    logic [RS-1:0]    v_r;
    logic [WIDTH-1:0] a_r [RS];
    logic [WIDTH-1:0] b_r [RS];
    logic [WIDTH-1:0] s_r [RS];
    logic [RS-1:0]    c_r;

    logic [WIDTH-1:0]  a_i [STAGES];
    logic [WIDTH-1:0]  b_i [STAGES];
    logic [WIDTH-1:0]  s_i [STAGES];
    logic [WIDTH-1:0]  s_o [STAGES];
    logic [STAGES-1:0] c_i;
    logic [STAGES-1:0] c_o;

    function automatic logic [BLOCK:0] cla(input logic [BLOCK-1:0] g,
                                           input logic [BLOCK-1:0] p,
                                           input logic c0);
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 1; i <= BLOCK; i++) begin
            term = c0;
            for (int m = 0; m < i; m++) term = term & p[m];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    assign adv      = (!out_valid || out_ready) && !rst;
    assign in_ready = adv;

    // Subtraction is x + ~y + 1; cin is overridden by the forced carry-in.
    assign a_i[0] = x;
    assign b_i[0] = sub ? ~y : y;
    assign c_i[0] = sub | cin;
    assign s_i[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [BLOCK-1:0] ga, gb, g, p;
        logic [BLOCK:0]   c;

        if (k > 0) begin : g_from_reg
            assign a_i[k] = a_r[k-1];
            assign b_i[k] = b_r[k-1];
            assign s_i[k] = s_r[k-1];
            assign c_i[k] = c_r[k-1];
        end

        assign ga     = a_i[k][k*BLOCK +: BLOCK];
        assign gb     = b_i[k][k*BLOCK +: BLOCK];
        assign g      = ga & gb;
        assign p      = ga ^ gb;
        assign c      = cla(g, p, c_i[k]);
        assign s_o[k] = s_i[k] | (WIDTH'(p ^ c[BLOCK-1:0]) << (k * BLOCK));
        assign c_o[k] = c[BLOCK];
    end

    if (STAGES == 1) begin : g_single
        assign last_v = in_valid;
    end else begin : g_multi
        assign last_v = v_r[STAGES-2];
    end

    assign ovf_n = (a_i[STAGES-1][WIDTH-1] == b_i[STAGES-1][WIDTH-1]) &&
                   (s_o[STAGES-1][WIDTH-1] != a_i[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            v_r       <= '0;
            out_valid <= 1'b0;
            z         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= last_v;
            if (last_v) begin
                z    <= s_o[STAGES-1];
                cout <= c_o[STAGES-1];
                ovf  <= ovf_n;
            end
            v_r[0] <= in_valid;
            for (int k = 1; k < RS; k++) v_r[k] <= v_r[k-1];
            for (int k = 0; k < RS; k++) begin
                a_r[k] <= a_i[k];
                b_r[k] <= b_i[k];
                s_r[k] <= s_o[k];
                c_r[k] <= c_o[k];
            end
        end
    end

endmodule
